// File: rtl/share_encoder3.sv
// Three-share masking encoder: splits a 2-bit plain word (a, b) into three
// Boolean shares plus fresh randomness for a 3-share DOM AND, driven by a 16-bit LFSR.
module share_encoder3 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  os0,
  output logic [1:0]  os1,
  output logic [1:0]  os2,
  output logic [2:0]  refreshing,
  output logic [7:0]  word_count
);

  typedef enum logic [0:0] {
    UNSEEDED = 1'b0,
    RUN      = 1'b1
  } state_t;

  localparam logic [15:0] ZERO_SEED_SUB = 16'hACE1;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [15:0] lfsr_r;
  logic [15:0] lfsr_nxt_s;
  logic        out_valid_r;
  logic        out_valid_nxt_s;
  logic [1:0]  os0_r;
  logic [1:0]  os1_r;
  logic [1:0]  os2_r;
  logic [2:0]  refreshing_r;
  logic [7:0]  word_count_r;
  logic        in_ready_s;
  logic        accept_s;
  logic        consume_s;

  // Fibonacci step with taps 16, 14, 13, 11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // An all-zero seed would lock the LFSR, so it is substituted.
  function automatic logic [15:0] seed_fix(input logic [15:0] s);
    return (s == 16'h0000) ? ZERO_SEED_SUB : s;
  endfunction

  // Input/output handshake qualifiers.
  always_comb begin
    in_ready_s = (state_r == RUN) && !seed_load && (!out_valid_r || out_ready);
    accept_s   = in_valid && in_ready_s;
    consume_s  = out_valid_r && out_ready;
  end

  // Next-state logic for the seeding FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      UNSEEDED: begin
        if (seed_load) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = UNSEEDED;
        end
      end
      RUN: begin
        state_nxt_s = RUN;
      end
      default: begin
        state_nxt_s = UNSEEDED;
      end
    endcase
  end

  // PRNG next value: load on seed_load, free-run in RUN, hold when unseeded.
  always_comb begin
    lfsr_nxt_s = lfsr_r;
    if (seed_load) begin
      lfsr_nxt_s = seed_fix(seed);
    end else if (state_r == RUN) begin
      lfsr_nxt_s = lfsr_step(lfsr_r);
    end else begin
      lfsr_nxt_s = lfsr_r;
    end
  end

  // Output word valid: set on accept, cleared on a consume with no refill.
  always_comb begin
    out_valid_nxt_s = out_valid_r;
    if (accept_s) begin
      out_valid_nxt_s = 1'b1;
    end else if (consume_s) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
  end

  // FSM, PRNG and valid registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= UNSEEDED;
      lfsr_r      <= 16'h0000;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      lfsr_r      <= lfsr_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

  // Share capture uses the pre-advance LFSR value; shares hold until the next accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      os0_r        <= 2'b00;
      os1_r        <= 2'b00;
      os2_r        <= 2'b00;
      refreshing_r <= 3'b000;
    end else if (accept_s) begin
      os1_r        <= lfsr_r[1:0];
      os2_r        <= lfsr_r[3:2];
      os0_r        <= in_data ^ lfsr_r[1:0] ^ lfsr_r[3:2];
      refreshing_r <= lfsr_r[6:4];
    end else begin
      os0_r        <= os0_r;
      os1_r        <= os1_r;
      os2_r        <= os2_r;
      refreshing_r <= refreshing_r;
    end
  end

  // Consumed-word counter, wraps naturally at 256.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_count_r <= 8'd0;
    end else if (consume_s) begin
      word_count_r <= word_count_r + 8'd1;
    end else begin
      word_count_r <= word_count_r;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign os0        = os0_r;
  assign os1        = os1_r;
  assign os2        = os2_r;
  assign refreshing = refreshing_r;
  assign word_count = word_count_r;

endmodule

// File: tb/tb_share_encoder3.sv
// Randomized self-checking bench for share_encoder3 against a cycle-level
// behavioural model of the masking encoder.
module tb_share_encoder3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'h0000;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_data = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  os0, os1, os2;
  logic [2:0]  refreshing;
  logic [7:0]  word_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_run;
  logic [15:0] m_s;
  bit          m_ov;
  logic [1:0]  m_os0, m_os1, m_os2, m_data;
  logic [2:0]  m_ref;
  logic [7:0]  m_cnt;

  share_encoder3 dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .os0(os0), .os1(os1), .os2(os2), .refreshing(refreshing),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return ((s << 1) & 16'hFFFF) | {15'd0, fb};
  endfunction

  function automatic bit exp_ready();
    return m_run && !seed_load && (!m_ov || out_ready);
  endfunction

  // Advance one clock and update the model from the inputs applied this cycle.
  task automatic step();
    bit acc, cons;
    acc  = in_valid && exp_ready();
    cons = m_ov && out_ready;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_run = 0; m_s = 16'h0000; m_ov = 0;
      m_os0 = 2'b00; m_os1 = 2'b00; m_os2 = 2'b00; m_ref = 3'b000; m_cnt = 8'd0;
    end else begin
      if (cons) m_cnt = m_cnt + 8'd1;
      if (acc) begin
        m_os1 = m_s[1:0];
        m_os2 = m_s[3:2];
        m_os0 = in_data ^ m_s[1:0] ^ m_s[3:2];
        m_ref = m_s[6:4];
        m_data = in_data;
        m_ov = 1;
      end else if (cons) begin
        m_ov = 0;
      end
      if (seed_load) begin
        m_s = (seed == 16'h0000) ? 16'hACE1 : seed;
        m_run = 1;
      end else if (m_run) begin
        m_s = lfsr_next(m_s);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; seed_load = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    in_valid = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || word_count !== 8'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: out_valid=%b word_count=%0d in_ready=%b expected 0 0 0",
               out_valid, word_count, in_ready);
    end
    checks++;
    if ({os0, os1, os2, refreshing} !== 9'd0) begin
      errors++;
      $display("FAIL reset_data: os0=%b os1=%b os2=%b ref=%b expected all zero",
               os0, os1, os2, refreshing);
    end
  endtask

  task automatic test_unseeded();
    in_valid = 1'b1; in_data = 2'b10; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL unseeded_ready: got %b expected 0", in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL unseeded_valid: got %b expected 0", out_valid);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_seed_one();
    seed_load = 1'b1; seed = 16'h0001; in_valid = 1'b0;
    step();
    seed_load = 1'b0; in_valid = 1'b1; in_data = 2'b11;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL seed1_ready: got %b expected 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || os1 !== 2'b01 || os2 !== 2'b00 || os0 !== 2'b10 || refreshing !== 3'b000) begin
      errors++;
      $display("FAIL seed1_word: v=%b os0=%b os1=%b os2=%b ref=%b expected 1 10 01 00 000",
               out_valid, os0, os1, os2, refreshing);
    end
  endtask

  task automatic test_seed_zero();
    logic [1:0] d;
    out_ready = 1'b1; in_valid = 1'b0;
    seed_load = 1'b1; seed = 16'h0000;
    step();
    seed_load = 1'b0;
    d = 2'($urandom_range(0, 3));
    in_valid = 1'b1; in_data = d;
    step();
    checks++;
    if (os1 !== 2'b01 || os2 !== 2'b00 || refreshing !== 3'b110 || os0 !== (d ^ 2'b01)) begin
      errors++;
      $display("FAIL seed0_first: os0=%b os1=%b os2=%b ref=%b expected %b 01 00 110",
               os0, os1, os2, refreshing, d ^ 2'b01);
    end
    in_data = 2'($urandom_range(0, 3));
    step();
    in_valid = 1'b0;
    checks++;
    if (os0 !== m_os0 || os1 !== m_os1 || os2 !== m_os2 || refreshing !== m_ref) begin
      errors++;
      $display("FAIL seed0_second: os0=%b os1=%b os2=%b ref=%b expected %b %b %b %b",
               os0, os1, os2, refreshing, m_os0, m_os1, m_os2, m_ref);
    end
  endtask

  task automatic test_stall();
    logic [8:0] held;
    logic [7:0] cnt;
    out_ready = 1'b1; in_valid = 1'b0;
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 2'($urandom_range(0, 3));
    step();
    held = {os0, os1, os2, refreshing};
    cnt  = word_count;
    for (int i = 0; i < 5; i++) begin
      in_data   = 2'($urandom_range(0, 3));
      seed_load = (i == 2);
      seed      = 16'($urandom);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready: cycle %0d got %b expected 0", i, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || {os0, os1, os2, refreshing} !== held || word_count !== cnt) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d v=%b word=%h cnt=%0d expected 1 %h %0d",
                 i, out_valid, {os0, os1, os2, refreshing}, word_count, held, cnt);
      end
    end
    seed_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || word_count !== cnt + 8'd1) begin
      errors++;
      $display("FAIL stall_release: v=%b cnt=%0d expected 0 %0d", out_valid, word_count, cnt + 8'd1);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    seed_load = 1'b1; seed = 16'($urandom);
    step();
    seed_load = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = 2'($urandom_range(0, 3));
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready: word %0d got %b expected 1", i, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || (os0 ^ os1 ^ os2) !== m_data || os1 !== m_os1 ||
          os2 !== m_os2 || refreshing !== m_ref) begin
        errors++;
        $display("FAIL b2b_word: word %0d v=%b xor=%b os1=%b os2=%b ref=%b expected 1 %b %b %b %b",
                 i, out_valid, os0 ^ os1 ^ os2, os1, os2, refreshing, m_data, m_os1, m_os2, m_ref);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (word_count !== 8'd44 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: cnt=%0d v=%b expected 44 0", word_count, out_valid);
    end
  endtask

  task automatic test_random();
    seed_load = 1'b1; seed = 16'($urandom);
    step();
    for (int i = 0; i < 400; i++) begin
      seed_load = ($urandom_range(0, 19) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      checks++;
      if (in_ready !== exp_ready()) begin
        errors++;
        $display("FAIL rand_ready: cycle %0d got %b expected %b", i, in_ready, exp_ready());
      end
      step();
      checks++;
      if (out_valid !== m_ov || word_count !== m_cnt || os0 !== m_os0 || os1 !== m_os1 ||
          os2 !== m_os2 || refreshing !== m_ref) begin
        errors++;
        $display("FAIL rand_out: cycle %0d v=%b cnt=%0d os=%b%b%b ref=%b expected %b %0d %b%b%b %b",
                 i, out_valid, word_count, os0, os1, os2, refreshing,
                 m_ov, m_cnt, m_os0, m_os1, m_os2, m_ref);
      end
    end
  endtask

  task automatic test_reset_mid();
    seed_load = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: out_valid=%b expected 1", out_valid);
    end
    rst_n = 1'b0; out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || word_count !== 8'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_post: v=%b cnt=%0d in_ready=%b expected 0 0 0",
               out_valid, word_count, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_unseeded: v=%b expected 0", out_valid);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unseeded();
    test_seed_one();
    test_seed_zero();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
